board_cover: RTL and testbench

- Per-cell cover-state store for the minesweeper board: tracks whether each cell is covered, flagged or opened.
- Applies player flag/open commands to the currently addressed cell and reports that cell's cover state combinationally.
- Emits a one-cycle pulse when a cell is newly opened, so the game FSM can decrement its cells-to-open counter.
- Sits beside the mine/number board store; the top level combines the two into the apparent cell value.

---
 rtl/board_cover_if.sv | 23 ++
 rtl/board_cover.sv | 86 ++++++++
 tb/tb_board_cover.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/board_cover_if.sv
// Command/status bundle between the game controller and the per-cell cover store.
interface board_cover_if #(
  parameter int unsigned X_COORD_BITS = 4,
  parameter int unsigned Y_COORD_BITS = 4
);
  logic                                flag;
  logic                                open;
  logic [X_COORD_BITS-1:0]             x_coord;
  logic [Y_COORD_BITS-1:0]             y_coord;
  logic [1:0]                          cell_val;
  logic                                opened_cell;
  logic [X_COORD_BITS+Y_COORD_BITS:0]  flag_count;

  modport master (
    output flag, open, x_coord, y_coord,
    input  cell_val, opened_cell, flag_count
  );

  modport slave (
    input  flag, open, x_coord, y_coord,
    output cell_val, opened_cell, flag_count
  );
endinterface

// File: rtl/board_cover.sv
// Per-cell cover state (covered / opened / flagged) for the minesweeper board,
// with a combinational read of the addressed cell and a newly-opened pulse.
module board_cover #(
  parameter int unsigned X_SIZE       = 16,
  parameter int unsigned Y_SIZE       = 16,
  parameter int unsigned X_COORD_BITS = 4,
  parameter int unsigned Y_COORD_BITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  board_cover_if.slave  bus
);
  localparam int unsigned CELLS    = X_SIZE * Y_SIZE;
  localparam int unsigned IDX_BITS = X_COORD_BITS + Y_COORD_BITS;
  localparam int unsigned CNT_W    = IDX_BITS + 1;

  typedef enum logic [1:0] {
    CELL_COVERED = 2'b00,
    CELL_OPENED  = 2'b01,
    CELL_FLAGGED = 2'b10
  } cell_state_e;

  cell_state_e         cells [CELLS];
  logic [IDX_BITS-1:0] idx;
  logic                in_range;
  cell_state_e         cur;
  cell_state_e         wr_val;
  logic                wr_en;
  logic                pulse_d;
  logic                cnt_inc;
  logic                cnt_dec;

  always_comb begin
    in_range = (32'(bus.x_coord) < X_SIZE) && (32'(bus.y_coord) < Y_SIZE);
    idx      = IDX_BITS'(32'(bus.y_coord) * X_SIZE + 32'(bus.x_coord));
    cur      = cells[idx];
  end

  assign bus.cell_val = in_range ? cur : 2'b00;

  // flag wins over open; flagged cells are protected from opening
  always_comb begin
    wr_en   = 1'b0;
    wr_val  = cur;
    pulse_d = 1'b0;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    if (in_range) begin
      if (bus.flag) begin
        if (cur == CELL_FLAGGED) begin
          wr_en   = 1'b1;
          wr_val  = CELL_COVERED;
          cnt_dec = 1'b1;
        end else if (cur == CELL_COVERED) begin
          wr_en   = 1'b1;
          wr_val  = CELL_FLAGGED;
          cnt_inc = 1'b1;
        end
      end else if (bus.open && cur == CELL_COVERED) begin
        wr_en   = 1'b1;
        wr_val  = CELL_OPENED;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CELLS; i++) begin
        cells[i] <= CELL_COVERED;
      end
      bus.opened_cell <= 1'b0;
      bus.flag_count  <= '0;
    end else begin
      if (wr_en) begin
        cells[idx] <= wr_val;
      end
      bus.opened_cell <= pulse_d;
      if (cnt_inc && bus.flag_count != CNT_W'(CELLS)) begin
        bus.flag_count <= bus.flag_count + CNT_W'(1);
      end else if (cnt_dec && bus.flag_count != '0) begin
        bus.flag_count <= bus.flag_count - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_board_cover.sv
// Directed plus random checks of two board_cover instances (16x16 and 12x10)
// against a cell-array reference model.
module tb_board_cover;
  logic clk = 1'b0;
  logic rst = 1'b1;

  board_cover_if #(.X_COORD_BITS(4), .Y_COORD_BITS(4)) b0 ();
  board_cover_if #(.X_COORD_BITS(4), .Y_COORD_BITS(4)) b1 ();

  board_cover #(.X_SIZE(16), .Y_SIZE(16), .X_COORD_BITS(4), .Y_COORD_BITS(4))
    dut0 (.clk(clk), .reset(rst), .bus(b0.slave));
  board_cover #(.X_SIZE(12), .Y_SIZE(10), .X_COORD_BITS(4), .Y_COORD_BITS(4))
    dut1 (.clk(clk), .reset(rst), .bus(b1.slave));

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errs    = 0;

  // model: 0 covered, 1 opened, 2 flagged
  int mdl [2][256];
  int exp_pulse [2];
  logic cur_f, cur_o;
  int cur_x, cur_y;
  int pulses [2];

  function automatic int xsz(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic int ysz(input int d);
    return (d == 0) ? 16 : 10;
  endfunction

  function automatic bit inr(input int d);
    return (cur_x < xsz(d)) && (cur_y < ysz(d));
  endfunction

  function automatic int exp_val(input int d);
    return inr(d) ? mdl[d][cur_y * xsz(d) + cur_x] : 0;
  endfunction

  function automatic int exp_cnt(input int d);
    int n = 0;
    for (int i = 0; i < xsz(d) * ysz(d); i++) if (mdl[d][i] == 2) n++;
    return n;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mdl[d][i] = 0;
      exp_pulse[d] = 0;
    end
  endtask

  task automatic drive(input logic f, input logic o, input int x, input int y);
    cur_f = f; cur_o = o; cur_x = x; cur_y = y;
    b0.flag = f; b0.open = o; b0.x_coord = 4'(x); b0.y_coord = 4'(y);
    b1.flag = f; b1.open = o; b1.x_coord = 4'(x); b1.y_coord = 4'(y);
  endtask

  // what one clock edge does to the model, using the command present now
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      exp_pulse[d] = 0;
      if (inr(d)) begin
        int i = cur_y * xsz(d) + cur_x;
        if (cur_f) begin
          if (mdl[d][i] == 2) mdl[d][i] = 0;
          else if (mdl[d][i] == 0) mdl[d][i] = 2;
        end else if (cur_o && mdl[d][i] == 0) begin
          mdl[d][i] = 1;
          exp_pulse[d] = 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_val0"}, 32'(b0.cell_val),    32'(exp_val(0)));
    check({tag, "_pls0"}, 32'(b0.opened_cell), 32'(exp_pulse[0]));
    check({tag, "_cnt0"}, 32'(b0.flag_count),  32'(exp_cnt(0)));
    check({tag, "_val1"}, 32'(b1.cell_val),    32'(exp_val(1)));
    check({tag, "_pls1"}, 32'(b1.opened_cell), 32'(exp_pulse[1]));
    check({tag, "_cnt1"}, 32'(b1.flag_count),  32'(exp_cnt(1)));
  endtask

  task automatic look(input string tag, input int x, input int y);
    drive(1'b0, 1'b0, x, y);
    #1;
    check_all(tag);
  endtask

  // one command cycle: apply, clock, drop the command, check the addressed cell
  task automatic step(input string tag, input logic f, input logic o, input int x, input int y);
    drive(f, o, x, y);
    @(posedge clk);
    model_edge();
    #1;
    drive(1'b0, 1'b0, x, y);
    pulses[0] += int'(b0.opened_cell);
    pulses[1] += int'(b1.opened_cell);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    clear_model();
    #1;
    check_all(tag);
    drive(1'b1, 1'b1, 3, 3);
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    drive(1'b0, 1'b0, 3, 3);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all({tag, "_rel"});
  endtask

  initial begin
    clear_model();
    pulses[0] = 0; pulses[1] = 0;
    drive(1'b0, 1'b0, 0, 0);
    #3;
    look("rst_0_0", 0, 0);
    look("rst_15_15", 15, 15);
    look("rst_7_3", 7, 3);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    step("open_3_5", 1'b0, 1'b1, 3, 5);
    idle("open_3_5_after");
    step("reopen_3_5", 1'b0, 1'b1, 3, 5);

    step("flag_2_2", 1'b1, 1'b0, 2, 2);
    step("open_flagged", 1'b0, 1'b1, 2, 2);
    step("unflag_2_2", 1'b1, 1'b0, 2, 2);

    step("open_4_4", 1'b0, 1'b1, 4, 4);
    step("flag_opened", 1'b1, 1'b0, 4, 4);
    step("flag_open_6_6", 1'b1, 1'b1, 6, 6);

    // command held for two edges toggles the flag twice
    drive(1'b1, 1'b0, 8, 8);
    @(posedge clk); model_edge(); #1; check_all("hold_1");
    @(posedge clk); model_edge(); #1; drive(1'b0, 1'b0, 8, 8); check_all("hold_2");

    // beyond the 12x10 board but inside the 16x16 one
    step("oor_x_flag", 1'b1, 1'b0, 13, 2);
    step("oor_y_open", 1'b0, 1'b1, 5, 11);
    step("oor_both", 1'b1, 1'b0, 15, 15);

    step("flag_1_1", 1'b1, 1'b0, 1, 1);
    step("open_9_9", 1'b0, 1'b1, 9, 9);
    async_reset("areset");
    look("areset_1_1", 1, 1);
    look("areset_9_9", 9, 9);

    for (int n = 0; n < 400; n++) begin
      logic f, o;
      f = ($urandom_range(0, 3) == 0);
      o = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) idle("rand_idle");
      else step("rand", f, o, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    async_reset("areset2");
    pulses[0] = 0; pulses[1] = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) step("raster", 1'b0, 1'b1, x, y);
    check("raster_pulses0", 32'(pulses[0]), 32'd256);
    check("raster_pulses1", 32'(pulses[1]), 32'd120);
    pulses[0] = 0; pulses[1] = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) step("reopen", 1'b0, 1'b1, x, y);
    check("reopen_pulses0", 32'(pulses[0]), 32'd0);
    check("reopen_pulses1", 32'(pulses[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
